dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit between the datapath (register-file read ports and ALU address) and the word-wide data RAM.
- Turns lw/lh/lhu/lb/lbu/sw/sh/sb requests into word accesses on the RAM.
- Sub-word stores use read-modify-write; loads use lane extraction and sign or zero extension.
- Reports completion, misalignment and out-of-range addresses to the control unit through a req/done handshake.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte address of RAM word 0.
- DEPTH_WORDS, 2048, RAM depth in 32-bit words; the valid range is [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).

Ports:
- clk  in  1  Single clock; all state updates on posedge.
- rst  in  1  Asynchronous, active-low reset; 0 forces reset immediately.
- req  in  1  Request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  Access size: 00 byte, 01 half, 10 word; 11 is treated as an error.
- sign_ext  in  1  Loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  Byte address.
- wdata  in  32  Store data, right-aligned.
- rdata  out  32  Load result; valid while done=1 and held until the next load completes.
- done  out  1  One-cycle completion pulse.
- err  out  1  Valid with done; 1 = misaligned, out of range, or size=11.
- busy  out  1  1 whenever state≠IDLE.
- mem_ena  out  1  RAM read enable.
- mem_wena  out  1  RAM write enable.
- mem_addr  out  32  Word-aligned byte address {addr_q[31:2],2'b00}; 0 in IDLE.
- mem_wdata  out  32  Merged write word.
- mem_rdata  in  32  RAM combinational read data.

Behaviour:
- States: IDLE, RD, WR, RESP.
- In IDLE with req=1: latch addr, wdata, size, we and sign_ext into *_q registers, then evaluate errors.
  - Error: size=11; half with addr[0]=1; word with addr[1:0]≠0; or address outside the valid range.
  - On any error go to RESP with err=1. mem_ena and mem_wena stay 0 for the whole transaction.
- Load: IDLE→RD→RESP.
  - In RD: mem_ena=1; mem_rdata is captured into rbuf at the posedge leaving RD.
  - In RESP: rdata = extract(rbuf), done=1.
- Word store: IDLE→WR→RESP. In WR: mem_wena=1, mem_wdata=wdata_q.
- Sub-word store: IDLE→RD→WR→RESP.
  - In RD: capture the old word.
  - In WR: write the merged word; only the addressed lanes are replaced.
- RESP→IDLE unconditionally.
  - A new request can be accepted the cycle after done.
  - req while busy is ignored.
- Latency, counting the req cycle as cycle 0: word store done at cycle 2; load done at cycle 2; sub-word store done at cycle 3; error done at cycle 1.
- Lanes are little-endian.
  - Byte k = bits [8k+7:8k] for addr[1:0]=k.
  - Half at addr[1]=0 → [15:0]; addr[1]=1 → [31:16].
- Extension:
  - sign_ext=1 replicates the MSB of the extracted byte or half.
  - Word loads ignore sign_ext.
  - Stores ignore sign_ext.
- mem_ena, mem_wena and mem_addr are decoded combinationally from state only, so they are glitch-free relative to req.
- Reset values: state IDLE; rdata 0; done 0; err 0; busy 0; mem_ena 0; mem_wena 0; mem_addr 0; mem_wdata 0; all *_q and rbuf 0.
- Reset mid-transaction: mem_wena drops as soon as rst falls, with no partial write; done is not issued.
- rdata keeps its previous value on stores and error responses.

Optional Feature:
- Macro: DMEM_BYTE_MASK_EN.
- With the macro:
  - An extra output, mem_bmask [3:0] (byte-write mask), is added.
  - Sub-word stores skip RD (IDLE→WR→RESP). Data is replicated to all lanes and mem_bmask selects the lanes.
  - Word store mask is 4'b1111; the mask is 0 outside WR.
- Without the macro: no mem_bmask port; read-modify-write as described above.

Decomposition:
- Package dmem_pkg:
  - Size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State encoding (IDLE, RD, WR, RESP).
  - Default BASE_ADDR and DEPTH_WORDS.
- One combinational sub-module, dmem_lane:
  - Load extract/extend: (word, addr[1:0], size, sign_ext) → rdata.
  - Store merge: (old word, wdata, addr[1:0], size) → merged word and byte mask.
- The FSM and registers stay in dmem_lsu.

Test Plan:
- Reset: pull rst low mid-cycle while IDLE → all outputs 0 immediately; busy=0.
- sw: addr 0x1001_0004, wdata 0xDEAD_BEEF → cycle 1 WR with mem_wena=1, mem_addr 0x1001_0004, mem_wdata 0xDEAD_BEEF; cycle 2 done=1, err=0; mem_ena never 1.
- sb: addr 0x1001_0006, wdata 0x0000_0012, word already holds 0xDEAD_BEEF → RD then WR with mem_wdata 0xDE12_BEEF; done at cycle 3. With DMEM_BYTE_MASK_EN: no RD, mem_wdata 0x1212_1212, mem_bmask 4'b0100.
- Loads on word 0xDE12_BEEF:
  - lb 0x1001_0007 → 0xFFFF_FFDE
  - lbu → 0x0000_00DE
  - lh 0x1001_0006 → 0xFFFF_DE12
  - lhu → 0x0000_DE12
  - lw 0x1001_0004 → 0xDE12_BEEF
- Errors → done at cycle 1 with err=1; mem_ena and mem_wena stay 0 throughout:
  - lw 0x1001_0002
  - sh 0x1001_0005
  - lw 0x0000_0000 (out of range)
  - size=11
- Reset during the WR cycle of sw 0x1001_0008 ← 0x1234_5678 → mem_wena falls with rst; a later lw 0x1001_0008 returns the old value; done never pulses for the aborted store.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size codes, FSM state encoding and default memory map for the load/store unit
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h1001_0000;
  localparam int DEPTH_WORDS_DEF = 2048;
endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: little-endian lane extraction/extension for loads and lane merge for stores
// With DMEM_BYTE_MASK_EN the store word is the replicated data plus a byte mask instead of a merged word.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] ld,
`ifdef DMEM_BYTE_MASK_EN
  output logic [3:0]  mask,
`endif
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [3:0]  bm;
  logic [31:0] rep;
`ifndef DMEM_BYTE_MASK_EN
  logic [31:0] bm32;
`endif
  // select the addressed lane, extend it, and build the lane mask and replicated store data
  always_comb begin
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    ld = size == SZ_BYTE ? {{24{sign_ext & b[7]}}, b} :
         size == SZ_HALF ? {{16{sign_ext & h[15]}}, h} : word;
    bm = size == SZ_BYTE ? 4'b0001 << off :
         size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    rep = size == SZ_BYTE ? {4{wdata[7:0]}} :
          size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
`ifdef DMEM_BYTE_MASK_EN
    mask = bm;
    merged = rep;
`else
    bm32 = {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
    merged = (word & ~bm32) | (rep & bm32);
`endif
  end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit turning byte/half/word requests into word RAM accesses
// Optional DMEM_BYTE_MASK_EN: adds mem_bmask and replaces sub-word read-modify-write with masked writes.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        mem_ena,
  output logic        mem_wena,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
`ifdef DMEM_BYTE_MASK_EN
  output logic [3:0]  mem_bmask,
`endif
  input  logic [31:0] mem_rdata
);
`ifdef DMEM_BYTE_MASK_EN
  localparam state_t SUB_ST = WR;
  logic [3:0] mask;
`else
  localparam state_t SUB_ST = RD;
`endif
  state_t      state;
  logic [31:0] addr_q, wdata_q, rbuf, ld, merged, off;
  logic [1:0]  size_q;
  logic        we_q, sx_q, err_q, bad;

  dmem_lane u_lane (
    .word     (state == RD ? mem_rdata : rbuf),
    .wdata    (wdata_q),
    .off      (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sx_q),
    .ld       (ld),
`ifdef DMEM_BYTE_MASK_EN
    .mask     (mask),
`endif
    .merged   (merged)
  );

  // flag bad size, misalignment and addresses outside the RAM window for the incoming request
  always_comb begin
    off = addr - BASE_ADDR;
    bad = size == 2'b11 || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00) ||
          addr < BASE_ADDR || off >= 32'(4 * DEPTH_WORDS);
  end

  // transaction FSM with request latches, read buffer and load result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      sx_q    <= 1'b0;
      err_q   <= 1'b0;
      rbuf    <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          addr_q  <= addr;
          wdata_q <= wdata;
          size_q  <= size;
          we_q    <= we;
          sx_q    <= sign_ext;
          err_q   <= bad;
          state   <= bad ? RESP : !we ? RD : size == SZ_WORD ? WR : SUB_ST;
        end
        RD: begin
          rbuf  <= mem_rdata;
          rdata <= we_q ? rdata : ld;
          state <= we_q ? WR : RESP;
        end
        WR:      state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM strobes and status decoded from state alone so they never follow req combinationally
  always_comb begin
    done      = state == RESP;
    err       = done & err_q;
    busy      = state != IDLE;
    mem_ena   = state == RD;
    mem_wena  = state == WR;
    mem_addr  = busy ? {addr_q[31:2], 2'b00} : '0;
    mem_wdata = mem_wena ? merged : '0;
`ifdef DMEM_BYTE_MASK_EN
    mem_bmask = mem_wena ? mask : 4'b0000;
`endif
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu with a small behavioural word RAM
module tb_dmem_lsu;
  import dmem_pkg::*;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        done, err, busy, mem_ena, mem_wena;
  logic [3:0]  wmask;
  logic [31:0] ram [16];

  typedef struct {string nm; logic e; logic chk; logic [31:0] rd; int lat; int ena; int wena;} exp_t;
  typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] m;} wr_t;
  exp_t eq[$];
  wr_t  wq[$];
  exp_t ex;
  wr_t  wx;
  int vectors = 0, miscompares = 0, lat_c = 0, ena_c = 0, wena_c = 0;

`ifdef DMEM_BYTE_MASK_EN
  logic [3:0] mem_bmask;
  assign wmask = mem_bmask;
`else
  assign wmask = 4'hF;
`endif

  dmem_lsu dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DMEM_BYTE_MASK_EN
    .mem_bmask(mem_bmask),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[5:2]];

  always @(posedge clk)
    if (mem_wena)
      for (int i = 0; i < 4; i++)
        if (wmask[i]) ram[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: pops expected writes and responses whenever the DUT presents them
  always @(negedge clk) begin
    if (!rst) begin
      lat_c = 0; ena_c = 0; wena_c = 0;
    end else begin
      if (busy) begin
        lat_c++;
        ena_c += int'(mem_ena);
        wena_c += int'(mem_wena);
      end
      if (mem_wena) begin
        if (wq.size() == 0) check("spurious write", 32'(mem_wena), 32'd0);
        else begin
          wx = wq.pop_front();
          check("write addr", mem_addr, wx.a);
          check("write data", mem_wdata, wx.d);
`ifdef DMEM_BYTE_MASK_EN
          check("write mask", 32'(mem_bmask), 32'(wx.m));
`endif
        end
      end
      if (done) begin
        if (eq.size() == 0) check("spurious done", 32'(done), 32'd0);
        else begin
          ex = eq.pop_front();
          check({ex.nm, " err"}, 32'(err), 32'(ex.e));
          if (ex.chk) check({ex.nm, " rdata"}, rdata, ex.rd);
          check({ex.nm, " latency"}, lat_c, ex.lat);
          check({ex.nm, " mem_ena cycles"}, ena_c, ex.ena);
          check({ex.nm, " mem_wena cycles"}, wena_c, ex.wena);
        end
        lat_c = 0; ena_c = 0; wena_c = 0;
      end
    end
  end

  task automatic wexp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    wq.push_back(wr_t'{a, d, m});
  endtask

  task automatic issue(input string nm, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d, input logic e, input logic chk,
                       input logic [31:0] rd, input int lat, input int ena, input int wena);
    eq.push_back(exp_t'{nm, e, chk, rd, lat, ena, wena});
    @(posedge clk); #2;
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(posedge clk); #2;
    req = 1'b0; addr = $urandom; wdata = $urandom; sign_ext = ~sx;
    for (int i = 0; i < 8 && busy; i++) begin
      @(posedge clk); #2;
    end
    if (busy) check({nm, " timeout busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " rdata"}, rdata, 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " mem_ena"}, 32'(mem_ena), 32'd0);
    check({tag, " mem_wena"}, 32'(mem_wena), 32'd0);
    check({tag, " mem_addr"}, mem_addr, 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'h0101_0101 * i;
    ram[2] = 32'hCAFE_F00D;
    #1 rst = 1'b0;
    #9 chk_reset("power-on reset");
    #2 rst = 1'b1;
    wexp(BASE + 4, 32'hDEAD_BEEF, 4'hF);
    issue("sw", 1, SZ_WORD, 0, BASE + 4, 32'hDEAD_BEEF, 0, 0, 0, 2, 0, 1);
`ifdef DMEM_BYTE_MASK_EN
    wexp(BASE + 4, 32'h1212_1212, 4'b0100);
    issue("sb", 1, SZ_BYTE, 0, BASE + 6, 32'h0000_0012, 0, 0, 0, 2, 0, 1);
`else
    wexp(BASE + 4, 32'hDE12_BEEF, 4'hF);
    issue("sb", 1, SZ_BYTE, 0, BASE + 6, 32'h0000_0012, 0, 0, 0, 3, 1, 1);
`endif
    issue("lb",  0, SZ_BYTE, 1, BASE + 7, 0, 0, 1, 32'hFFFF_FFDE, 2, 1, 0);
    issue("lbu", 0, SZ_BYTE, 0, BASE + 7, 0, 0, 1, 32'h0000_00DE, 2, 1, 0);
    issue("lh",  0, SZ_HALF, 1, BASE + 6, 0, 0, 1, 32'hFFFF_DE12, 2, 1, 0);
    issue("lhu", 0, SZ_HALF, 0, BASE + 6, 0, 0, 1, 32'h0000_DE12, 2, 1, 0);
    issue("lw",  0, SZ_WORD, 1, BASE + 4, 0, 0, 1, 32'hDE12_BEEF, 2, 1, 0);
    issue("lb lane0", 0, SZ_BYTE, 1, BASE + 4, 0, 0, 1, 32'hFFFF_FFEF, 2, 1, 0);
    issue("lbu lane1", 0, SZ_BYTE, 0, BASE + 5, 0, 0, 1, 32'h0000_00BE, 2, 1, 0);
    issue("lh low", 0, SZ_HALF, 1, BASE + 4, 0, 0, 1, 32'hFFFF_BEEF, 2, 1, 0);
`ifdef DMEM_BYTE_MASK_EN
    wexp(BASE + 4, 32'h5555_5555, 4'b1100);
    issue("sh", 1, SZ_HALF, 1, BASE + 6, 32'hAAAA_5555, 0, 0, 0, 2, 0, 1);
`else
    wexp(BASE + 4, 32'h5555_BEEF, 4'hF);
    issue("sh", 1, SZ_HALF, 1, BASE + 6, 32'hAAAA_5555, 0, 0, 0, 3, 1, 1);
`endif
    issue("lh positive", 0, SZ_HALF, 1, BASE + 6, 0, 0, 1, 32'h0000_5555, 2, 1, 0);
    issue("lw after sh", 0, SZ_WORD, 0, BASE + 4, 0, 0, 1, 32'h5555_BEEF, 2, 1, 0);
    wexp(BASE + 32'h1FFC, 32'h0BAD_F00D, 4'hF);
    issue("sw last word", 1, SZ_WORD, 0, BASE + 32'h1FFC, 32'h0BAD_F00D, 0, 0, 0, 2, 0, 1);
    issue("lw last word", 0, SZ_WORD, 0, BASE + 32'h1FFC, 0, 0, 1, 32'h0BAD_F00D, 2, 1, 0);
    issue("lw misaligned", 0, SZ_WORD, 0, BASE + 2, 0, 1, 1, 32'h0BAD_F00D, 1, 0, 0);
    issue("sh misaligned", 1, SZ_HALF, 0, BASE + 5, 32'h1111_2222, 1, 1, 32'h0BAD_F00D, 1, 0, 0);
    issue("lw addr 0", 0, SZ_WORD, 0, 32'h0, 0, 1, 1, 32'h0BAD_F00D, 1, 0, 0);
    issue("size 11", 0, 2'b11, 0, BASE + 4, 0, 1, 1, 32'h0BAD_F00D, 1, 0, 0);
    issue("lw past end", 0, SZ_WORD, 0, BASE + 32'h2000, 0, 1, 1, 32'h0BAD_F00D, 1, 0, 0);
    issue("sw below base", 1, SZ_WORD, 0, BASE - 4, 32'h3333_4444, 1, 1, 32'h0BAD_F00D, 1, 0, 0);
    @(posedge clk); #3 rst = 1'b0;
    #1 chk_reset("idle reset");
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2;
    req = 1'b1; we = 1'b1; size = SZ_WORD; addr = BASE + 8; wdata = 32'h1234_5678;
    @(posedge clk); #2 req = 1'b0;
    check("abort mem_wena in WR", 32'(mem_wena), 32'd1);
    #1 rst = 1'b0;
    #1 check("abort mem_wena after rst", 32'(mem_wena), 32'd0);
    check("abort busy after rst", 32'(busy), 32'd0);
    check("abort done after rst", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    issue("lw after abort", 0, SZ_WORD, 0, BASE + 8, 0, 0, 1, 32'hCAFE_F00D, 2, 1, 0);
    repeat (3) @(posedge clk);
    #2 check("responses outstanding", eq.size(), 32'd0);
    check("writes outstanding", wq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
